// File: rtl/riscv_core_branch_ctrl.sv
// ============================================================================
//  Module   : riscv_core_branch_ctrl
//  Brief    : EX-stage branch resolution controller. Detects mispredicts and
//             misaligned taken targets, sequences flush + fetch redirect or an
//             instruction-address-misaligned trap, and keeps branch statistics.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_core_branch_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_branch_ctrl_valid,
    output logic             o_branch_ctrl_ready,
    input  logic             i_branch_ctrl_istaken,
    input  logic             i_branch_ctrl_addr_mismatch,
    input  logic             i_branch_ctrl_is_jump,
    input  logic             i_branch_ctrl_pred_taken,
    input  logic [XLEN-1:0]  i_branch_ctrl_pc,
    input  logic [XLEN-1:0]  i_branch_ctrl_target,
    output logic             o_branch_ctrl_flush,
    output logic             o_branch_ctrl_redirect_valid,
    output logic [XLEN-1:0]  o_branch_ctrl_redirect_pc,
    input  logic             i_branch_ctrl_redirect_ready,
    output logic             o_branch_ctrl_trap_valid,
    output logic [3:0]       o_branch_ctrl_trap_cause,
    output logic [XLEN-1:0]  o_branch_ctrl_trap_tval,
    input  logic             i_branch_ctrl_trap_ack,
    output logic             o_branch_ctrl_stall,
    input  logic             i_branch_ctrl_clr_cnt,
    output logic [CNT_W-1:0] o_branch_ctrl_branch_cnt,
    output logic [CNT_W-1:0] o_branch_ctrl_mispredict_cnt
);

    localparam logic [3:0] c_cause_misaligned = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_flush;
    logic              r_redirect_valid;
    logic [XLEN-1:0]   r_redirect_pc;
    logic              r_trap_valid;
    logic [XLEN-1:0]   r_trap_tval;
    logic              r_stall;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_mispredict_cnt;

    logic              w_ready;
    logic              w_accept;
    logic              w_taken;
    logic              w_mis;
    logic              w_mp;
    logic              w_redirect_start;
    logic              w_trap_start;
    logic [XLEN-1:0]   w_redirect_pc_nxt;

    assign w_ready  = (r_state == ST_IDLE);
    assign w_accept = i_branch_ctrl_valid & w_ready;

    // Misalignment only matters when control actually leaves the fall-through path.
    assign w_taken  = i_branch_ctrl_istaken | i_branch_ctrl_is_jump;
    assign w_mis    = i_branch_ctrl_addr_mismatch & w_taken;
    assign w_mp     = (w_taken != i_branch_ctrl_pred_taken);

    assign w_trap_start     = w_accept & w_mis;
    assign w_redirect_start = w_accept & w_mp & ~w_mis;

    assign w_redirect_pc_nxt = w_taken ? i_branch_ctrl_target
                                       : (i_branch_ctrl_pc + XLEN'(4));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_trap_start) begin
                    w_state_nxt = ST_TRAP;
                end else if (w_redirect_start) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (i_branch_ctrl_redirect_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TRAP: begin
                if (i_branch_ctrl_trap_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request and stall flags track the next state so they drop on the completing edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= ST_IDLE;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_trap_valid     <= 1'b0;
            r_stall          <= 1'b0;
            r_redirect_pc    <= '0;
            r_trap_tval      <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_flush          <= w_trap_start | w_redirect_start;
            r_redirect_valid <= (w_state_nxt == ST_REDIRECT);
            r_trap_valid     <= (w_state_nxt == ST_TRAP);
            r_stall          <= (w_state_nxt != ST_IDLE);
            if (w_redirect_start) begin
                r_redirect_pc <= w_redirect_pc_nxt;
            end
            if (w_trap_start) begin
                r_trap_tval <= i_branch_ctrl_target;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (i_branch_ctrl_clr_cnt) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_redirect_start) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    assign o_branch_ctrl_ready          = w_ready;
    assign o_branch_ctrl_flush          = r_flush;
    assign o_branch_ctrl_redirect_valid = r_redirect_valid;
    assign o_branch_ctrl_redirect_pc    = r_redirect_pc;
    assign o_branch_ctrl_trap_valid     = r_trap_valid;
    assign o_branch_ctrl_trap_cause     = c_cause_misaligned;
    assign o_branch_ctrl_trap_tval      = r_trap_tval;
    assign o_branch_ctrl_stall          = r_stall;
    assign o_branch_ctrl_branch_cnt     = r_branch_cnt;
    assign o_branch_ctrl_mispredict_cnt = r_mispredict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_riscv_core_branch_ctrl.sv
// ============================================================================
//  Module   : tb_riscv_core_branch_ctrl
//  Brief    : Directed self-checking bench for riscv_core_branch_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_riscv_core_branch_ctrl;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             valid;
    logic             ready;
    logic             istaken;
    logic             addr_mismatch;
    logic             is_jump;
    logic             pred_taken;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  target;
    logic             flush;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             redirect_ready;
    logic             trap_valid;
    logic [3:0]       trap_cause;
    logic [XLEN-1:0]  trap_tval;
    logic             trap_ack;
    logic             stall;
    logic             clr_cnt;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    int total = 0;
    int bad   = 0;

    riscv_core_branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
        .i_clk                        (clk),
        .i_rst                        (rst),
        .i_branch_ctrl_valid          (valid),
        .o_branch_ctrl_ready          (ready),
        .i_branch_ctrl_istaken        (istaken),
        .i_branch_ctrl_addr_mismatch  (addr_mismatch),
        .i_branch_ctrl_is_jump        (is_jump),
        .i_branch_ctrl_pred_taken     (pred_taken),
        .i_branch_ctrl_pc             (pc),
        .i_branch_ctrl_target         (target),
        .o_branch_ctrl_flush          (flush),
        .o_branch_ctrl_redirect_valid (redirect_valid),
        .o_branch_ctrl_redirect_pc    (redirect_pc),
        .i_branch_ctrl_redirect_ready (redirect_ready),
        .o_branch_ctrl_trap_valid     (trap_valid),
        .o_branch_ctrl_trap_cause     (trap_cause),
        .o_branch_ctrl_trap_tval      (trap_tval),
        .i_branch_ctrl_trap_ack       (trap_ack),
        .o_branch_ctrl_stall          (stall),
        .i_branch_ctrl_clr_cnt        (clr_cnt),
        .o_branch_ctrl_branch_cnt     (branch_cnt),
        .o_branch_ctrl_mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic tk, input logic mm, input logic jp,
                         input logic pt, input logic [63:0] p, input logic [63:0] t);
        valid = v; istaken = tk; addr_mismatch = mm; is_jump = jp;
        pred_taken = pt; pc = p; target = t;
    endtask

    initial begin
        rst = 1'b1; redirect_ready = 1'b0; trap_ack = 1'b0; clr_cnt = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        step(); step();
        check("rst_ready",  64'(ready), 64'd1);
        check("rst_stall",  64'(stall), 64'd0);
        check("rst_flush",  64'(flush), 64'd0);
        check("rst_bcnt",   64'(branch_cnt), 64'd0);
        check("rst_rpc",    redirect_pc, 64'h0);
        rst = 1'b0;
        step();

        // Correct taken prediction
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0F00, 64'h1000);
        step();
        valid = 1'b0;
        check("ok_flush",   64'(flush), 64'd0);
        check("ok_ready",   64'(ready), 64'd1);
        check("ok_bcnt",    64'(branch_cnt), 64'd1);
        check("ok_mcnt",    64'(mispredict_cnt), 64'd0);
        step();
        check("ok_flush2",  64'(flush), 64'd0);

        // Not-taken mispredict with redirect back-pressure
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2000, 64'h2100);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h5000, 64'h5100);
        trap_ack = 1'b1;
        check("mp_flush",   64'(flush), 64'd1);
        check("mp_rvalid",  64'(redirect_valid), 64'd1);
        check("mp_rpc",     redirect_pc, 64'h2004);
        check("mp_stall",   64'(stall), 64'd1);
        check("mp_ready",   64'(ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_flush",  64'(flush), 64'd0);
            check("bp_rvalid", 64'(redirect_valid), 64'd1);
            check("bp_rpc",    redirect_pc, 64'h2004);
            check("bp_stall",  64'(stall), 64'd1);
            check("bp_bcnt",   64'(branch_cnt), 64'd2);
        end
        trap_ack = 1'b0; valid = 1'b0; redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        check("rd_rvalid",  64'(redirect_valid), 64'd0);
        check("rd_stall",   64'(stall), 64'd0);
        check("rd_ready",   64'(ready), 64'd1);
        check("rd_tvalid",  64'(trap_valid), 64'd0);
        check("rd_bcnt",    64'(branch_cnt), 64'd2);
        check("rd_mcnt",    64'(mispredict_cnt), 64'd1);

        // Misaligned jump target raises a trap
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h3000, 64'h3001);
        step();
        valid = 1'b0; redirect_ready = 1'b1;
        check("tr_valid",   64'(trap_valid), 64'd1);
        check("tr_tval",    trap_tval, 64'h3001);
        check("tr_cause",   64'(trap_cause), 64'd0);
        check("tr_rvalid",  64'(redirect_valid), 64'd0);
        check("tr_flush",   64'(flush), 64'd1);
        check("tr_stall",   64'(stall), 64'd1);
        check("tr_mcnt",    64'(mispredict_cnt), 64'd1);
        check("tr_bcnt",    64'(branch_cnt), 64'd3);
        step();
        redirect_ready = 1'b0; trap_ack = 1'b1;
        check("tr_hold",    64'(trap_valid), 64'd1);
        check("tr_flush2",  64'(flush), 64'd0);
        check("tr_rvalid2", 64'(redirect_valid), 64'd0);
        step();
        trap_ack = 1'b0;
        check("ta_valid",   64'(trap_valid), 64'd0);
        check("ta_ready",   64'(ready), 64'd1);
        check("ta_stall",   64'(stall), 64'd0);

        // Mismatch flag on a not-taken, correctly predicted branch is harmless
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h3100, 64'h3103);
        step();
        valid = 1'b0;
        check("nt_trap",    64'(trap_valid), 64'd0);
        check("nt_flush",   64'(flush), 64'd0);
        check("nt_bcnt",    64'(branch_cnt), 64'd4);

        // pc+4 wraps at the top of the address space
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10);
        step();
        valid = 1'b0; redirect_ready = 1'b1;
        check("wr_rpc",     redirect_pc, 64'h0);
        check("wr_rvalid",  64'(redirect_valid), 64'd1);
        step();
        check("wr_done",    64'(redirect_valid), 64'd0);

        // Taken mispredict, redirect_ready already high at the accept edge
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4000, 64'h4800);
        step();
        valid = 1'b0;
        check("tk_rpc",     redirect_pc, 64'h4800);
        check("tk_rvalid",  64'(redirect_valid), 64'd1);
        step();
        redirect_ready = 1'b0;
        check("tk_done",    64'(redirect_valid), 64'd0);
        check("tk_bcnt",    64'(branch_cnt), 64'd6);
        check("tk_mcnt",    64'(mispredict_cnt), 64'd3);

        // Clear wins over a simultaneous accept, then 16 accepts wrap the counter
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h6000, 64'h6100);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("clr_bcnt",   64'(branch_cnt), 64'd0);
        check("clr_mcnt",   64'(mispredict_cnt), 64'd0);
        for (int i = 0; i < 15; i++) step();
        check("cnt_15",     64'(branch_cnt), 64'd15);
        step();
        valid = 1'b0;
        check("cnt_wrap",   64'(branch_cnt), 64'd0);

        // Asynchronous reset while a redirect is pending
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h7000, 64'h7100);
        step();
        valid = 1'b0;
        check("pr_rvalid",  64'(redirect_valid), 64'd1);
        check("pr_mcnt",    64'(mispredict_cnt), 64'd1);
        rst = 1'b1;
        #1;
        check("ar_rvalid",  64'(redirect_valid), 64'd0);
        check("ar_stall",   64'(stall), 64'd0);
        check("ar_bcnt",    64'(branch_cnt), 64'd0);
        check("ar_mcnt",    64'(mispredict_cnt), 64'd0);
        check("ar_rpc",     redirect_pc, 64'h0);
        step();
        rst = 1'b0;
        step();
        check("ar_ready",   64'(ready), 64'd1);
        check("ar_flush",   64'(flush), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
